muldiv_iter: RTL and testbench
==============================

# muldiv_iter

Iterative integer multiply/divide unit for the execute stage, parametrised in datapath width and multiply radix. It covers the full RV64M/RV32M operation set: low/high multiply with signed/unsigned mixes, signed/unsigned divide and remainder, and 32-bit word forms. Divide-by-zero and signed overflow take a one-cycle fast path. It connects through valid/ready handshakes with a tag, and it supports pipeline flush.

## Interface
- XLEN, 64: datapath width; 32 or 64.
- MUL_BITS, 4: multiplier bits retired per multiply cycle; power of two, 1..16, divides 32.
- TAG_W, 5: width of the opaque tag carried from request to response.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  unit idle; the request is accepted on an edge where in_valid && in_ready && !flush.
- in_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in_word  in  1  32-bit form (MULW/DIVW/...). Ignored when XLEN=32.
- in_a, in_b  in  XLEN  operands (dividend/multiplicand a, divisor/multiplier b).
- in_tag  in  TAG_W  returned unchanged on out_tag.
- flush  in  1  abort the in-flight operation and drop any pending result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  tag of the result.
- out_div_zero  out  1  the result came from a divide/remainder by zero.
- out_overflow  out  1  the result came from signed most-negative ÷ −1.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE. in_ready = (state==IDLE).
- Acceptance latches the operands, op, word and tag.
- Word mode: operands are reduced to their low 32 bits, then sign- or zero-extended per op. Effective width W is 32 in word mode, otherwise XLEN.
- Signed operands are converted to magnitudes, and the negate flags are recorded. Negation is 2's complement modulo W.
- MUL state: a 2W-bit accumulator adds (mag_b × MUL_BITS-bit slice of mag_a) << position each cycle. The state runs W/MUL_BITS cycles, then goes to FIX.
- DIV state: restoring division, 1 quotient bit per cycle, MSB first. The state runs W cycles, then goes to FIX.
- FIX state: applies sign correction and selects the result, then goes to DONE.
  - Quotient sign = sa^sb.
  - Remainder sign = sa.
  - MUL returns the low W bits. MULH/MULHSU/MULHU return the high W bits.
  - In word mode, the low 32 bits are sign-extended to XLEN, for all ops including DIVUW/REMUW.
  - MULH* ops with in_word=1 behave as MUL (low half).
- Fast paths: on acceptance, the unit goes directly to DONE.
  - Divisor (in W bits) == 0: quotient = all ones, remainder = dividend (W bits, sign-extended in word mode), out_div_zero = 1.
  - Signed DIV/REM with dividend = −2^(W−1) and divisor = −1: quotient = dividend, remainder = 0, out_overflow = 1.
- DONE state: out_valid = 1, and out_result, out_tag and the flags are held stable until out_valid && out_ready, then the unit returns to IDLE. A new request can be accepted on the following edge, not on the same edge.
- flush: on any edge with flush = 1, the state goes to IDLE, out_valid drops, and no request is accepted. Flush wins over in_valid and out_ready on the same edge.

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, out_result = 0, out_tag = 0, out_div_zero = 0, out_overflow = 0. Reset mid-operation behaves like flush and also clears the outputs.
- Latency is counted from the acceptance edge to the first cycle with out_valid high, in edges:
  - multiply: W/MUL_BITS + 2 (64-bit, MUL_BITS=4: 18; word: 10).
  - divide: W + 2 (64-bit: 66; word: 34).
  - fast path: 1.
- Throughput: one operation in flight; the unit stalls under back-pressure.
- The flags are valid only with out_valid, and both are 0 for normal results.

## Configuration
- MULDIV_EARLY_OUT_EN defined:
  - MUL leaves for FIX as soon as the remaining unprocessed bits of mag_a are zero.
  - Divide with mag_a < mag_b takes the fast path: quotient 0, remainder = a (sign-extended in word mode), no flags.
- MULDIV_EARLY_OUT_EN undefined: latency is fixed as listed under Timing, regardless of operand values.

## Test plan
- XLEN=64, MUL_BITS=4, MULH, a=−3, b=5: out_result = all ones (high half of −15), 18 edges after acceptance, and the tag is echoed.
- DIV with a=7, b=0: quotient 0xFFFF_FFFF_FFFF_FFFF with out_div_zero = 1. REM with the same operands returns 7. Both arrive 1 edge after acceptance.
- DIVW with a=0x8000_0000, b=0xFFFF_FFFF: out_result = 0xFFFF_FFFF_8000_0000 with out_overflow = 1. REMW with the same operands returns 0.
- REM with a=−7, b=2: result −1 after 66 edges. DIVUW with a=0xFFFF_FFFE, b=1: result 0xFFFF_FFFF_FFFF_FFFE after 34 edges.
- Hold out_ready = 0 for 5 cycles after out_valid rises: out_result and out_tag stay stable and in_ready stays 0. The result is consumed on the edge where out_ready = 1, and in_ready = 1 on the next cycle.
- Assert flush in the 10th DIV cycle: no out_valid is ever produced for that request. A new MULU request accepted 1 edge later completes normally; with MULDIV_EARLY_OUT_EN, MUL with a=1 finishes in 3 edges.

Source files
------------

// File: rtl/muldiv_iter.sv
// Iterative RV64M/RV32M multiply/divide unit with valid/ready handshakes.
// Optional MULDIV_EARLY_OUT_EN: early multiply exit and small-dividend fast path.
module muldiv_iter #(
    parameter int XLEN     = 64,
    parameter int MUL_BITS = 4,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_word,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_div_zero,
    output logic             out_overflow
);
    localparam int CW = $clog2(XLEN);
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t state, state_n;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   a_sh;
    logic [2*XLEN-1:0] b_sh, acc, mul_step;
    logic [2:0]        op_q;
    logic              word_q, neg_a_q, neg_b_q;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic            word_in, div_in, sgn_a, sgn_b, neg_a, neg_b;
    logic            b_zero, ovf_in, small_in, fast_in, mul_early;
    logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, a_sx, fast_res, min_mag;

    always_comb begin
        word_in  = in_word && (XLEN == 64);
        div_in   = in_op[2];
        sgn_a    = (in_op == OP_MULH || in_op == OP_MULHSU || in_op == 3'd4 ||
                    in_op == 3'd6) && !(word_in && !div_in);
        sgn_b    = (in_op == OP_MULH || in_op == 3'd4 || in_op == 3'd6) &&
                   !(word_in && !div_in);
        a_sx     = word_in ? sext32(in_a[31:0]) : in_a;
        a_ext    = in_a;
        b_ext    = in_b;
        if (word_in) begin
            a_ext = sgn_a ? sext32(in_a[31:0]) : XLEN'(in_a[31:0]);
            b_ext = sgn_b ? sext32(in_b[31:0]) : XLEN'(in_b[31:0]);
        end
        neg_a    = sgn_a && a_ext[XLEN-1];
        neg_b    = sgn_b && b_ext[XLEN-1];
        mag_a    = neg_a ? -a_ext : a_ext;
        mag_b    = neg_b ? -b_ext : b_ext;
        min_mag  = word_in ? XLEN'(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        b_zero   = b_ext == '0;
        // most-negative / -1: both negative, |b| = 1, |a| = 2^(W-1)
        ovf_in   = div_in && neg_a && neg_b && mag_b == XLEN'(1) &&
                   mag_a == min_mag;
`ifdef MULDIV_EARLY_OUT_EN
        small_in = div_in && (mag_a < mag_b);
`else
        small_in = 1'b0;
`endif
        fast_in  = div_in && (b_zero || ovf_in || small_in);
        if (b_zero)      fast_res = in_op[1] ? a_sx : '1;
        else if (ovf_in) fast_res = in_op[1] ? '0 : a_sx;
        else             fast_res = in_op[1] ? a_sx : '0;
    end

    assign in_ready  = state == S_IDLE;
    assign out_valid = state == S_DONE;

    logic            accept;
    logic            ge;
    logic [XLEN:0]   trial, diff;
    logic [XLEN-1:0] rem_n;
    assign accept = in_valid && in_ready && !flush;

    always_comb begin
        mul_step = acc + b_sh * (2*XLEN)'(a_sh[MUL_BITS-1:0]);
        trial    = {acc[2*XLEN-1:XLEN], a_sh[XLEN-1]};
        diff     = trial - {1'b0, b_sh[XLEN-1:0]};
        ge       = trial >= {1'b0, b_sh[XLEN-1:0]};
        rem_n    = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
`ifdef MULDIV_EARLY_OUT_EN
        mul_early = (a_sh >> MUL_BITS) == '0;
`else
        mul_early = 1'b0;
`endif
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, raw, fix_res;
    always_comb begin
        prod = (neg_a_q ^ neg_b_q) ? -acc : acc;
        quo  = (neg_a_q ^ neg_b_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_a_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (!op_q[2])
            raw = (op_q == OP_MUL || word_q) ? prod[XLEN-1:0]
                                             : prod[2*XLEN-1:XLEN];
        else
            raw = op_q[1] ? rem : quo;
        fix_res = word_q ? sext32(raw[31:0]) : raw;
    end

    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: if (in_valid)
                    state_n = fast_in ? S_DONE : (div_in ? S_DIV : S_MUL);
                S_MUL:  if (cnt == '0 || mul_early) state_n = S_FIX;
                S_DIV:  if (cnt == '0) state_n = S_FIX;
                S_FIX:  state_n = S_DONE;
                S_DONE: if (out_ready) state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            a_sh         <= '0;
            b_sh         <= '0;
            acc          <= '0;
            op_q         <= '0;
            word_q       <= 1'b0;
            neg_a_q      <= 1'b0;
            neg_b_q      <= 1'b0;
            out_result   <= '0;
            out_tag      <= '0;
            out_div_zero <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (accept) begin
                    op_q         <= in_op;
                    word_q       <= word_in;
                    neg_a_q      <= neg_a;
                    neg_b_q      <= neg_b;
                    out_tag      <= in_tag;
                    // word divide: align the 32-bit dividend to the MSB end
                    a_sh         <= (div_in && word_in) ? mag_a << 32 : mag_a;
                    b_sh         <= (2*XLEN)'(mag_b);
                    acc          <= '0;
                    if (div_in)
                        cnt <= word_in ? CW'(31) : CW'(XLEN-1);
                    else
                        cnt <= word_in ? CW'(32/MUL_BITS-1)
                                       : CW'(XLEN/MUL_BITS-1);
                    out_result   <= fast_res;
                    out_div_zero <= div_in && b_zero;
                    out_overflow <= ovf_in && !b_zero;
                end
                S_MUL: begin
                    acc  <= mul_step;
                    a_sh <= a_sh >> MUL_BITS;
                    b_sh <= b_sh << MUL_BITS;
                    cnt  <= cnt - CW'(1);
                end
                S_DIV: begin
                    acc  <= {rem_n, acc[XLEN-2:0], ge};
                    a_sh <= a_sh << 1;
                    cnt  <= cnt - CW'(1);
                end
                S_FIX: out_result <= fix_res;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_iter.sv
// Randomised self-checking bench for muldiv_iter against an arithmetic model.
// Expected latencies follow MULDIV_EARLY_OUT_EN when it is defined.
module tb_muldiv_iter;
    localparam int XLEN = 64;
    localparam int MB   = 4;
    localparam int TW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready, in_word, flush;
    logic [2:0]      in_op;
    logic [XLEN-1:0] in_a, in_b, out_result;
    logic [TW-1:0]   in_tag, out_tag;
    logic            out_valid, out_ready, out_div_zero, out_overflow;

    muldiv_iter #(.XLEN(XLEN), .MUL_BITS(MB), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_word(in_word),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .out_div_zero(out_div_zero), .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic void model(input logic [2:0] op, input logic w,
                                  input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] res,
                                  output logic dz, output logic ov);
        longint      sa, sb, mn;
        logic [63:0] ua, ub;
        logic [127:0] p;
        dz  = 1'b0;
        ov  = 1'b0;
        res = '0;
        ua  = w ? {32'b0, a[31:0]} : a;
        ub  = w ? {32'b0, b[31:0]} : b;
        sa  = w ? longint'($signed(a[31:0])) : longint'(a);
        sb  = w ? longint'($signed(b[31:0])) : longint'(b);
        mn  = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        if (!op[2]) begin
            if (w || op == 3'd0) p = {64'b0, ua} * {64'b0, ub};
            else if (op == 3'd1)
                p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
            else if (op == 3'd2)
                p = $signed({{64{a[63]}}, a}) * $signed({64'b0, b});
            else p = {64'b0, a} * {64'b0, b};
            res = (w || op == 3'd0) ? p[63:0] : p[127:64];
        end else if (!op[0]) begin
            if (sb == 0) begin
                dz  = 1'b1;
                res = op[1] ? sa : '1;
            end else if (sa == mn && sb == -1) begin
                ov  = 1'b1;
                res = op[1] ? 64'd0 : sa;
            end else begin
                res = op[1] ? sa % sb : sa / sb;
            end
        end else begin
            if (ub == 0) begin
                dz  = 1'b1;
                res = op[1] ? ua : '1;
            end else begin
                res = op[1] ? ua % ub : ua / ub;
            end
        end
        if (w) res = {{32{res[31]}}, res[31:0]};
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic w,
                                   input logic [63:0] a, input logic [63:0] b,
                                   input logic dz, input logic ov);
        int          wd;
        logic [63:0] av, bv, ma, mb;
        logic        sga, sgb;
        wd  = w ? 32 : 64;
        sga = (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd6) &&
              !(w && !op[2]);
        sgb = (op == 3'd1 || op == 3'd4 || op == 3'd6) && !(w && !op[2]);
        av  = w ? (sga ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]}) : a;
        bv  = w ? (sgb ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]}) : b;
        ma  = (sga && av[63]) ? -av : av;
        mb  = (sgb && bv[63]) ? -bv : bv;
        if (op[2]) begin
            if (dz || ov) return 1;
`ifdef MULDIV_EARLY_OUT_EN
            if (ma < mb) return 1;
`endif
            return (mb == 0) ? 1 : wd + 2;
        end
`ifdef MULDIV_EARLY_OUT_EN
        begin
            int nb, sl;
            nb = 0;
            for (int i = 0; i < 64; i++) if (ma[i]) nb = i + 1;
            sl = (nb + MB - 1) / MB;
            if (sl == 0) sl = 1;
            return sl + 2;
        end
`else
        return (ma == ma) ? wd / MB + 2 : 0;
`endif
    endfunction

    task automatic do_op(input string nm, input logic [2:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input int hold);
        logic [63:0]   er;
        logic          edz, eov;
        int            el, lat;
        logic [TW-1:0] tg;
        model(op, w, a, b, er, edz, eov);
        el = exp_lat(op, w, a, b, edz, eov);
        tg = TW'($urandom);
        check({nm, "_rdy"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_word  = w;
        in_a     = a;
        in_b     = b;
        in_tag   = tg;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = {$urandom, $urandom};
        in_b     = {$urandom, $urandom};
        in_tag   = TW'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_lat"}, 64'(lat), 64'(el));
        check({nm, "_res"}, out_result, er);
        check({nm, "_tag"}, 64'(out_tag), 64'(tg));
        check({nm, "_flg"}, {62'b0, out_div_zero, out_overflow}, {62'b0, edz, eov});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({nm, "_hold"}, {out_valid, in_ready, out_tag, out_result[56:0]},
                  {1'b1, 1'b0, tg, er[56:0]});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({nm, "_drain"}, {62'b0, out_valid, in_ready}, 64'b01);
    endtask

    function automatic logic [63:0] rnd_opnd();
        unique case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_8000_0000;
            4: return 64'h0000_0000_FFFF_FFFF;
            5: return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_word = 1'b0;
        in_a = '0; in_b = '0; in_tag = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset", {in_ready, out_valid, out_div_zero, out_overflow,
                        out_tag, out_result[54:0]}, 64'h8000_0000_0000_0000);

        do_op("mulh",  3'd1, 1'b0, -64'sd3, 64'd5, 0);
        do_op("div0",  3'd4, 1'b0, 64'd7, 64'd0, 0);
        do_op("rem0",  3'd6, 1'b0, 64'd7, 64'd0, 0);
        do_op("divw_ov", 3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 0);
        do_op("remw_ov", 3'd6, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 0);
        do_op("rem",   3'd6, 1'b0, -64'sd7, 64'd2, 0);
        do_op("divuw", 3'd5, 1'b1, 64'hFFFF_FFFE, 64'd1, 0);
        do_op("bp",    3'd3, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 5);

        // flush in the 10th divide cycle with a new request already waiting
        in_valid = 1'b1; in_op = 3'd5; in_word = 1'b0;
        in_a = 64'd1000; in_b = 64'd3; in_tag = 5'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        flush = 1'b1; in_valid = 1'b1; in_op = 3'd3;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush", {62'b0, seen | out_valid, in_ready}, 64'b01);
        do_op("post_flush", 3'd3, 1'b0, 64'd123456789, 64'hDEAD_BEEF, 0);
        do_op("mul_one", 3'd0, 1'b0, 64'd1, {$urandom, $urandom}, 0);

        // reset in the middle of a multiply clears everything
        in_valid = 1'b1; in_op = 3'd0; in_a = '1; in_b = '1; in_tag = 5'd31;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst", {in_ready, out_valid, out_div_zero, out_overflow,
                          out_tag, out_result[54:0]}, 64'h8000_0000_0000_0000);

        for (int k = 0; k < 150; k++)
            do_op("rnd", 3'($urandom_range(0, 7)), 1'($urandom),
                  rnd_opnd(), rnd_opnd(), $urandom_range(0, 2));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
